// File: rtl/mux_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mux_bus_arbiter
//   Round-robin arbiter for a shared 64-bit, 9:1 bus mux. It picks one owner
//   among nine requesters and drives a one-hot grant, the matching mux select
//   and a busy flag. All three outputs are registered. A request wins one
//   clock edge after it is first sampled. Requests are never latched.
//
// Parameters
//   MAX_BURST  consecutive grant cycles an owner may keep while another
//              requester waits (1..15). Used only when burst limiting is on.
//
// Ports
//   clk    in   1  sole clock, rising edge
//   reset  in   1  synchronous, active-high
//   req    in   9  per-requester request, req[i] <-> mux select i
//   grant  out  9  one-hot grant, zero when there is no owner
//   sel    out  4  owner index 0..8, zero when idle
//   busy   out  1  high exactly when grant is non-zero
//
// Build option
//   MUX_BUS_ARBITER_BURST_LIMIT_EN  when defined, an owner that has held the
//   bus for MAX_BURST cycles hands over if any other requester is waiting.
//   When undefined, an owner keeps the bus until it drops its request, and
//   the burst counter is not built.
// ---------------------------------------------------------------------------
module mux_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] req,
  output logic [8:0] grant,
  output logic [3:0] sel,
  output logic       busy
);

  typedef enum logic {IDLE, OWN} state_t;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_range
    $error("mux_bus_arbiter: MAX_BURST must be within 1..15");
  end

  state_t     r_state;
  logic [8:0] r_grant;
  logic [3:0] r_sel;
  logic       r_busy;
  logic [3:0] r_last;

  logic [3:0] w_pick;
  logic       w_any;
  logic       w_own_req;
  logic       w_force;

  // Search begins just after the last owner and wraps from 8 to 0. In OWN
  // the owner is also the last owner, so it is reached only after all eight
  // other requesters have been checked.
  function automatic logic [3:0] rr_pick(input logic [8:0] r,
                                         input logic [3:0] last);
    logic [3:0] idx;
    logic       found;
    rr_pick = 4'd0;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < 9; k++) begin
      idx = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_pick    = rr_pick(req, r_last);
  assign w_any     = |req;
  assign w_own_req = req[r_sel];

`ifdef MUX_BUS_ARBITER_BURST_LIMIT_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [3:0] r_burst;
  logic       w_other;

  // r_grant holds the owner's bit in OWN. Masking it out leaves only the
  // requesters that are waiting.
  assign w_other = |(req & ~r_grant);
  assign w_force = w_own_req && w_other && (r_burst == BURST_LAST);
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 9'd0;
      r_sel   <= 4'd0;
      r_busy  <= 1'b0;
      r_last  <= 4'd8;
`ifdef MUX_BUS_ARBITER_BURST_LIMIT_EN
      r_burst <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= OWN;
            r_grant <= 9'd1 << w_pick;
            r_sel   <= w_pick;
            r_busy  <= 1'b1;
            r_last  <= w_pick;
`ifdef MUX_BUS_ARBITER_BURST_LIMIT_EN
            r_burst <= 4'd0;
`endif
          end
        end
        OWN: begin
          if (!w_own_req || w_force) begin
            if (w_any) begin
              // The handover happens on this edge, so the bus never goes idle.
              r_state <= OWN;
              r_grant <= 9'd1 << w_pick;
              r_sel   <= w_pick;
              r_busy  <= 1'b1;
              r_last  <= w_pick;
`ifdef MUX_BUS_ARBITER_BURST_LIMIT_EN
              r_burst <= 4'd0;
`endif
            end else begin
              r_state <= IDLE;
              r_grant <= 9'd0;
              r_sel   <= 4'd0;
              r_busy  <= 1'b0;
`ifdef MUX_BUS_ARBITER_BURST_LIMIT_EN
              r_burst <= 4'd0;
`endif
            end
          end else begin
`ifdef MUX_BUS_ARBITER_BURST_LIMIT_EN
            // The counter saturates while nobody else is waiting.
            if (r_burst != BURST_LAST) begin
              r_burst <= r_burst + 4'd1;
            end
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 9'd0;
          r_sel   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;

endmodule
